lsu_mem_port: RTL and testbench

//   Load/store memory port between the MEM pipeline stage and the data-memory bus.

---
 rtl/lsu_mem_port.sv | 141 ++++++++++++++
 tb/tb_lsu_mem_port.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store memory port between the MEM stage and the data-memory bus.
// Checks alignment, issues one word-aligned bus access and hands the raw word to the load formatter.
module lsu_mem_port #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_mem_ctrl,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] ld_read_data,
  output logic [1:0]  ld_addr_low,
  output logic [2:0]  ld_mem_ctrl
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, ERR} state_t;

  state_t        state;
  state_t        state_next;
  logic          write_q;
  logic [29:0]   word_addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] count;
  logic          accept;
  logic          bad_access;
  logic          expired;
  logic [3:0]    be_raw;
  logic [31:0]   wdata_lanes;

  assign accept  = req_valid && req_ready;
  assign expired = (count == LAST_COUNT);

  // Reserved size and misaligned halfword/word go straight to ERR without touching the bus.
  always_comb begin
    bad_access = 1'b0;
    case (req_mem_ctrl[1:0])
      2'b01:   bad_access = req_addr[0];
      2'b10:   bad_access = |req_addr[1:0];
      2'b11:   bad_access = 1'b1;
      default: bad_access = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A grant or rvalid arriving in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = bad_access ? ERR : REQ;
      REQ: begin
        if (mem_gnt)      state_next = write_q ? DONE : RESP;
        else if (expired) state_next = ERR;
      end
      RESP: begin
        if (mem_rvalid)   state_next = DONE;
        else if (expired) state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (state_next != state) begin
      count <= '0;
    end else if (state == REQ || state == RESP) begin
      count <= count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q      <= 1'b0;
      word_addr_q  <= '0;
      wdata_q      <= '0;
      ld_addr_low  <= '0;
      ld_mem_ctrl  <= '0;
      ld_read_data <= '0;
    end else begin
      if (accept) begin
        write_q     <= req_write;
        word_addr_q <= req_addr[31:2];
        wdata_q     <= req_wdata;
        ld_addr_low <= req_addr[1:0];
        ld_mem_ctrl <= req_mem_ctrl;
      end
      if (state == RESP && mem_rvalid) ld_read_data <= mem_rdata;
    end
  end

  always_comb begin
    be_raw      = 4'b0000;
    wdata_lanes = wdata_q;
    case (ld_mem_ctrl[1:0])
      2'b00: begin
        be_raw      = 4'b0001 << ld_addr_low;
        wdata_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_raw      = ld_addr_low[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata_q[15:0]}};
      end
      2'b10:   be_raw = 4'b1111;
      default: be_raw = 4'b0000;
    endcase
  end

  // Bus fields are forced to zero outside REQ so the bus sees nothing between accesses.
  assign req_ready  = (state == IDLE);
  assign mem_req    = (state == REQ);
  assign mem_we     = mem_req && write_q;
  assign mem_addr   = mem_req ? {word_addr_q, 2'b00} : 32'h0;
  assign mem_be     = mem_req ? be_raw : 4'b0000;
  assign mem_wdata  = mem_req ? wdata_lanes : 32'h0;
  assign resp_valid = (state == DONE) || (state == ERR);
  assign resp_err   = (state == ERR);

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed table-driven bench for lsu_mem_port, with hand-written sequences for
// timeouts, the expiry race and reset while a load is in flight.
module tb_lsu_mem_port;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_mem_ctrl;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] ld_read_data;
  logic [1:0]  ld_addr_low;
  logic [2:0]  ld_mem_ctrl;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = 32'h0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    int          gnt_dly;
    logic [31:0] rdata;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[12];

  lsu_mem_port #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_mem_ctrl (req_mem_ctrl),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .ld_read_data (ld_read_data),
    .ld_addr_low  (ld_addr_low),
    .ld_mem_ctrl  (ld_mem_ctrl)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One complete access, starting in an IDLE cycle and ending in the DONE/ERR cycle.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    checkOutput("ready_idle", req_ready, 1);
    req_valid    = 1'b1;
    req_write    = v.write;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_mem_ctrl = v.ctrl;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("ld_addr_low_accept", ld_addr_low, v.addr[1:0]);
    checkOutput("ld_mem_ctrl_accept", ld_mem_ctrl, v.ctrl);
    if (v.exp_err) begin
      checkOutput("err_no_req", mem_req, 0);
      checkOutput("err_valid", resp_valid, 1);
      checkOutput("err_flag", resp_err, 1);
      checkOutput("err_rdata_kept", ld_read_data, model_rdata);
    end else begin
      for (int i = 0; i <= v.gnt_dly; i++) begin
        checkOutput("req_held", mem_req, 1);
        checkOutput("req_be", mem_be, v.exp_be);
        checkOutput("req_addr", mem_addr, v.exp_addr);
        checkOutput("req_we", mem_we, v.write);
        if (v.write) checkOutput("req_wdata", mem_wdata, v.exp_wdata);
        checkOutput("req_no_resp", resp_valid, 0);
        if (i == v.gnt_dly) mem_gnt = 1'b1;
        @(negedge clk);
      end
      mem_gnt = 1'b0;
      if (!v.write) begin
        checkOutput("resp_no_req", mem_req, 0);
        checkOutput("resp_no_valid", resp_valid, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        @(negedge clk);
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'hBAD0BAD0;
        model_rdata = v.rdata;
      end
      checkOutput("done_valid", resp_valid, 1);
      checkOutput("done_err", resp_err, 0);
      checkOutput("done_no_req", mem_req, 0);
      checkOutput("done_rdata", ld_read_data, model_rdata);
      checkOutput("done_addr_low", ld_addr_low, v.addr[1:0]);
      checkOutput("done_mem_ctrl", ld_mem_ctrl, v.ctrl);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h103, 32'h0,        3'b000, 0,  32'hAABBCCDD, 1'b0, 4'b1000, 32'h100, 32'h0};
    vecs[1]  = '{1'b1, 32'h202, 32'h00001234, 3'b001, 5,  32'h0,        1'b0, 4'b1100, 32'h200, 32'h12341234};
    vecs[2]  = '{1'b0, 32'h301, 32'h0,        3'b010, 0,  32'h0,        1'b1, 4'b0000, 32'h0,   32'h0};
    vecs[3]  = '{1'b1, 32'h400, 32'hDEADBEEF, 3'b010, 1,  32'h0,        1'b0, 4'b1111, 32'h400, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 32'h012, 32'h0,        3'b101, 2,  32'h11223344, 1'b0, 4'b1100, 32'h010, 32'h0};
    vecs[5]  = '{1'b1, 32'h005, 32'h123456A5, 3'b000, 0,  32'h0,        1'b0, 4'b0010, 32'h004, 32'hA5A5A5A5};
    vecs[6]  = '{1'b0, 32'h000, 32'h0,        3'b011, 0,  32'h0,        1'b1, 4'b0000, 32'h0,   32'h0};
    vecs[7]  = '{1'b1, 32'h001, 32'h5555,     3'b001, 0,  32'h0,        1'b1, 4'b0000, 32'h0,   32'h0};
    vecs[8]  = '{1'b1, 32'h080, 32'h0F0F1234, 3'b010, 63, 32'h0,        1'b0, 4'b1111, 32'h080, 32'h0F0F1234};
    vecs[9]  = '{1'b0, 32'h008, 32'h0,        3'b010, 0,  32'hCAFEF00D, 1'b0, 4'b1111, 32'h008, 32'h0};
    vecs[10] = '{1'b1, 32'h0A1, 32'h00000077, 3'b000, 0,  32'h0,        1'b0, 4'b0010, 32'h0A0, 32'h77777777};
    vecs[11] = '{1'b0, 32'h0A1, 32'h0,        3'b100, 0,  32'h000000F0, 1'b0, 4'b0010, 32'h0A0, 32'h0};

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    req_mem_ctrl = 3'b000;
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = 32'hBAD0BAD0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", req_ready, 1);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_be", mem_be, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_err", resp_err, 0);
    checkOutput("rst_ld_read_data", ld_read_data, 0);
    checkOutput("rst_ld_addr_low", ld_addr_low, 0);
    checkOutput("rst_ld_mem_ctrl", ld_mem_ctrl, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Load granted at once but read data never arrives.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_mem_ctrl = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clk);
    checkOutput("resp_timeout_pending", resp_valid, 0);
    @(negedge clk);
    checkOutput("resp_timeout_valid", resp_valid, 1);
    checkOutput("resp_timeout_err", resp_err, 1);
    checkOutput("resp_timeout_rdata_kept", ld_read_data, model_rdata);
    applyStimulus(vecs[0]);

    // Store that never receives a grant.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h1; req_mem_ctrl = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clk);
    checkOutput("req_timeout_still_req", mem_req, 1);
    @(negedge clk);
    checkOutput("req_timeout_dropped", mem_req, 0);
    checkOutput("req_timeout_valid", resp_valid, 1);
    checkOutput("req_timeout_err", resp_err, 1);
    applyStimulus(vecs[3]);

    // Reset asserted while a load waits in RESP; late rvalid must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h50; req_mem_ctrl = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("inflight_rst_mem_req", mem_req, 0);
    checkOutput("inflight_rst_resp_valid", resp_valid, 0);
    checkOutput("inflight_rst_ready", req_ready, 1);
    model_rdata = 32'h0;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55555555;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hBAD0BAD0;
    checkOutput("post_rst_resp_valid", resp_valid, 0);
    checkOutput("post_rst_rdata", ld_read_data, 0);
    checkOutput("post_rst_ready", req_ready, 1);
    applyStimulus(vecs[9]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
